// File: rtl/uart_tx_scheduler.sv
// Purpose: round-robin arbiter sharing one UART TX core between N_REQ byte producers, with inter-frame gap and start timeout.
// Latency: a byte accepted in IDLE cycle T raises tx_start in T+1; the next grant comes no earlier than GAP_CYC+1 clocks after tx_busy falls.
// Backpressure: req_ready is offered only in IDLE, one-hot to the round-robin winner; every requester stalls while a frame is in flight.
module uart_tx_scheduler #(
   parameter int N_REQ       = 4,
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 16,
   localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [ID_W-1:0]      grant_id,
   output logic                 active,
   output logic                 timeout_err,
   output logic [CNT_W-1:0]     frame_cnt
);

   // One timer serves both the start timeout and the gap, since they never overlap.
   localparam int TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

   logic [7:0]         req_byte [N_REQ];
   logic               win_vld;
   logic [ID_W-1:0]    win_idx;
   logic [ID_W-1:0]    cand;
   logic [TMR_W-1:0]   tmr_inc;

   assign tmr_inc     = tmr_q + TMR_W'(1);
   assign tx_start    = (state_q == ST_START);
   assign active      = (state_q != ST_IDLE);
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_q;
   assign timeout_err = err_q;
   assign frame_cnt   = frame_cnt_q;

   // Split the flat request bus into one byte per requester.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_byte[i] = req_data[8*i +: 8];
      end
   end

   // Round-robin search: first valid requester after the last one served, wrapping.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = ID_W'((int'(last_q) + i) % N_REQ);
         if (!win_vld && req_valid[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Ready goes only to the winner and only while idle, so at most one byte is accepted per frame.
   always_comb begin
      req_ready = '0;
      if (state_q == ST_IDLE && win_vld) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // Next-state logic: accept, pulse start, wait for busy to rise and fall, then hold off for the gap.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      tx_data_d   = tx_data_q;
      grant_d     = grant_q;
      tmr_d       = tmr_q;
      err_d       = err_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               tx_data_d = req_byte[win_idx];
               grant_d   = win_idx;
               last_d    = win_idx;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            tmr_d   = '0;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            // A busy already high during START is taken as the core having started.
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (tmr_inc == TO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr_inc;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               err_d       = 1'b0;
               tmr_d       = '0;
               state_d     = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (tmr_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset drops any pending byte and leaves requester 0 with first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_q      <= ID_W'(N_REQ - 1);
         tx_data_q   <= 8'h00;
         grant_q     <= '0;
         tmr_q       <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         tx_data_q   <= tx_data_d;
         grant_q     <= grant_d;
         tmr_q       <= tmr_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule
